// File: rtl/zet_rep_seq_if.sv
// Handshake bundle between the string-instruction sequencer and its surroundings:
// launch request, iteration handshake with the execution unit, and CX/completion results.
interface zet_rep_seq_if;
   logic        start;
   logic [1:0]  prefix;
   logic [6:0]  opcode;
   logic [15:0] cx_in;
   logic        iter_req;
   logic        iter_ack;
   logic        iter_done;
   logic        zf;
   logic        ext_int;
   logic [15:0] cx_out;
   logic        cx_we;
   logic        busy;
   logic        done;
   logic        int_exit;

   modport master (
      output start, prefix, opcode, cx_in, iter_ack, iter_done, zf, ext_int,
      input  iter_req, cx_out, cx_we, busy, done, int_exit
   );

   modport slave (
      input  start, prefix, opcode, cx_in, iter_ack, iter_done, zf, ext_int,
      output iter_req, cx_out, cx_we, busy, done, int_exit
   );
endinterface

// File: rtl/zet_rep_seq.sv
// REP-prefix sequencer: repeats a string instruction CX times, handling REPZ/REPNZ
// early exit and suspending between iterations for a pending external interrupt.
module zet_rep_seq (
   input  logic              clk,
   input  logic              rst,
   zet_rep_seq_if.slave      bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      FIN   = 3'd4
   } state_t;

   state_t      state_r;
   logic [15:0] cnt_r;
   logic        repz_r;
   logic        rep_mode_r;
   logic        cmp_sca_r;
   logic        first_done_r;

   logic        valid_op_s;
   logic        exit_z_s;
   logic [15:0] cnt_dec_s;

   // Decode the string opcodes that honour a REP prefix and the loop-exit terms.
   always_comb begin
      valid_op_s = 1'b0;
      case (bus.opcode)
         7'b1010010,
         7'b1010011,
         7'b1010101,
         7'b1010110,
         7'b1010111,
         7'b0110110,
         7'b0110111: valid_op_s = 1'b1;
         default:    valid_op_s = 1'b0;
      endcase
      cnt_dec_s = cnt_r - 16'd1;
      exit_z_s  = cmp_sca_r & (repz_r ? ~bus.zf : bus.zf);
   end

   // Sequencer state, iteration bookkeeping and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         cnt_r        <= 16'd0;
         repz_r       <= 1'b0;
         rep_mode_r   <= 1'b0;
         cmp_sca_r    <= 1'b0;
         first_done_r <= 1'b0;
         bus.iter_req <= 1'b0;
         bus.cx_out   <= 16'd0;
         bus.cx_we    <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.int_exit <= 1'b0;
      end else begin
         bus.cx_we    <= 1'b0;
         bus.done     <= 1'b0;
         bus.int_exit <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  cnt_r        <= bus.cx_in;
                  repz_r       <= bus.prefix[0];
                  rep_mode_r   <= bus.prefix[1] & valid_op_s;
                  cmp_sca_r    <= bus.opcode[1] & bus.opcode[0];
                  first_done_r <= 1'b0;
                  bus.busy     <= 1'b1;
                  state_r      <= CHECK;
               end else begin
                  bus.busy     <= 1'b0;
               end
            end
            CHECK: begin
               // Interrupts are only honoured once an iteration has completed.
               if (rep_mode_r && (cnt_r == 16'd0)) begin
                  bus.done     <= 1'b1;
                  state_r      <= FIN;
               end else if (rep_mode_r && bus.ext_int && first_done_r) begin
                  bus.done     <= 1'b1;
                  bus.int_exit <= 1'b1;
                  state_r      <= FIN;
               end else begin
                  bus.iter_req <= 1'b1;
                  state_r      <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.iter_ack) begin
                  bus.iter_req <= 1'b0;
                  state_r      <= WAIT;
               end else begin
                  bus.iter_req <= 1'b1;
               end
            end
            WAIT: begin
               if (bus.iter_done) begin
                  if (rep_mode_r) begin
                     cnt_r        <= cnt_dec_s;
                     bus.cx_out   <= cnt_dec_s;
                     bus.cx_we    <= 1'b1;
                     first_done_r <= 1'b1;
                     if (exit_z_s || (cnt_dec_s == 16'd0)) begin
                        bus.done <= 1'b1;
                        state_r  <= FIN;
                     end else begin
                        state_r  <= CHECK;
                     end
                  end else begin
                     bus.done <= 1'b1;
                     state_r  <= FIN;
                  end
               end
            end
            FIN: begin
               bus.busy <= 1'b0;
               state_r  <= IDLE;
            end
            default: begin
               bus.iter_req <= 1'b0;
               bus.busy     <= 1'b0;
               state_r      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zet_rep_seq.sv
// Randomized bench for zet_rep_seq: an execution-unit responder with random latencies,
// compared against an instruction-level model of REP semantics.
module tb_zet_rep_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   zet_rep_seq_if bus ();

   zet_rep_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   errors = 0;
   int   checks = 0;
   logic zfs [64];
   int   exp_writes [$];
   int   obs_writes [$];
   logic [6:0] ops [7] = '{7'b1010010, 7'b1010011, 7'b1010101, 7'b1010110,
                           7'b1010111, 7'b0110110, 7'b0110111};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit is_str(input logic [6:0] op);
      for (int i = 0; i < 7; i++)
         if (ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   task automatic idle_inputs();
      bus.start     = 1'b0;
      bus.prefix    = 2'd0;
      bus.opcode    = 7'd0;
      bus.cx_in     = 16'd0;
      bus.iter_ack  = 1'b0;
      bus.iter_done = 1'b0;
      bus.zf        = 1'b0;
      bus.ext_int   = 1'b0;
   endtask

   // int_after: ext_int is raised at the handshake of that iteration (0 = never)
   task automatic run_instr(input string name, input logic [1:0] pfx, input logic [6:0] op,
                            input logic [15:0] cx, input int int_after, input bit early,
                            input bit fast, input bit noise);
      bit rep, cmp, intx, end_chk, busy_after;
      int c, n, hs, dones, done_k, bad_int, dly;
      bit inflight, req_prev, ack_prev, intx_obs;

      // reference model: outcome of the whole instruction
      rep = pfx[1] && is_str(op);
      cmp = op[1] & op[0];
      c = int'(cx); n = 0; intx = 1'b0; end_chk = 1'b0;
      exp_writes.delete();
      obs_writes.delete();
      if (!rep) begin
         n = 1;
      end else begin
         forever begin
            if (c == 0) begin end_chk = 1'b1; break; end
            if (int_after != 0 && n >= int_after) begin intx = 1'b1; end_chk = 1'b1; break; end
            n++; c--;
            exp_writes.push_back(c);
            if (cmp && (pfx[0] ? !zfs[n-1] : zfs[n-1])) break;
            if (c == 0) break;
         end
      end

      @(negedge clk);
      bus.start = 1'b1; bus.prefix = pfx; bus.opcode = op; bus.cx_in = cx;
      bus.ext_int = early;
      @(negedge clk);
      bus.start = 1'b0;
      bus.prefix = 2'($urandom); bus.opcode = 7'($urandom); bus.cx_in = 16'($urandom);

      hs = 0; dones = 0; done_k = -1; bad_int = 0; dly = 0;
      inflight = 1'b0; req_prev = 1'b0; ack_prev = 1'b0; intx_obs = 1'b0; busy_after = 1'b1;
      for (int k = 1; k <= 3000; k++) begin
         if (bus.cx_we) obs_writes.push_back(int'(bus.cx_out));
         if (bus.int_exit && !bus.done) bad_int++;
         if (done_k >= 0 && k == done_k + 1) begin
            busy_after = bus.busy;
            if (bus.done) dones++;
            break;
         end
         if (bus.done) begin dones++; intx_obs = bus.int_exit; done_k = k; end
         if (ack_prev && req_prev) begin
            hs++;
            inflight = 1'b1;
            dly = fast ? 0 : $urandom_range(0, 2);
            if (int_after != 0 && hs == int_after) bus.ext_int = 1'b1;
         end
         bus.iter_done = 1'b0;
         bus.zf = 1'(($urandom));
         if (inflight) begin
            if (dly == 0) begin
               bus.iter_done = 1'b1;
               bus.zf = zfs[(hs - 1) % 64];
               inflight = 1'b0;
            end else begin
               dly--;
            end
         end else if (noise && $urandom_range(0, 3) == 0) begin
            bus.iter_done = 1'b1;
         end
         req_prev = bus.iter_req;
         if (bus.iter_req) bus.iter_ack = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
         else              bus.iter_ack = noise ? 1'($urandom) : 1'b0;
         ack_prev = bus.iter_ack;
         if (noise && bus.busy && $urandom_range(0, 3) == 0) begin
            bus.start = 1'b1; bus.prefix = 2'b10; bus.opcode = 7'b1010010; bus.cx_in = 16'd9;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      idle_inputs();

      if (done_k < 0) check_val({name, " timeout"}, 32'd1, 32'd0);
      check_val({name, " handshakes"}, 32'(hs), 32'(n));
      check_val({name, " cx_we count"}, 32'(obs_writes.size()), 32'(exp_writes.size()));
      for (int i = 0; i < exp_writes.size() && i < obs_writes.size(); i++)
         check_val({name, " cx_out"}, 32'(obs_writes[i]), 32'(exp_writes[i]));
      check_val({name, " done pulses"}, 32'(dones), 32'd1);
      check_val({name, " int_exit"}, 32'(intx_obs), 32'(intx));
      check_val({name, " int_exit w/o done"}, 32'(bad_int), 32'd0);
      check_val({name, " busy after fin"}, 32'(busy_after), 32'd0);
      if (fast)
         check_val({name, " done latency"}, 32'(done_k), end_chk ? 32'(2 + 3 * n) : 32'(1 + 3 * n));
   endtask

   // Abort in WAIT: outputs must clear and no completion must follow.
   task automatic reset_mid();
      int late;
      @(negedge clk);
      bus.start = 1'b1; bus.prefix = 2'b10; bus.opcode = 7'b1010010; bus.cx_in = 16'd10;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check_val("rstmid iter_req", 32'(bus.iter_req), 32'd1);
      bus.iter_ack = 1'b1;
      @(negedge clk);
      bus.iter_ack = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("rstmid iter_req low", 32'(bus.iter_req), 32'd0);
      check_val("rstmid busy", 32'(bus.busy), 32'd0);
      check_val("rstmid done", 32'(bus.done), 32'd0);
      late = 0;
      bus.iter_done = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         bus.iter_done = 1'b0;
         if (bus.done || bus.cx_we || bus.busy || bus.iter_req) late++;
      end
      check_val("rstmid quiet", 32'(late), 32'd0);
   endtask

   initial begin
      idle_inputs();
      for (int i = 0; i < 64; i++) zfs[i] = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst iter_req", 32'(bus.iter_req), 32'd0);
      check_val("rst cx_we",    32'(bus.cx_we),    32'd0);
      check_val("rst done",     32'(bus.done),     32'd0);
      check_val("rst int_exit", 32'(bus.int_exit), 32'd0);
      check_val("rst busy",     32'(bus.busy),     32'd0);
      check_val("rst cx_out",   32'(bus.cx_out),   32'd0);
      rst = 1'b0;

      run_instr("rep_movs3", 2'b10, 7'b1010010, 16'd3, 0, 1'b0, 1'b1, 1'b0);
      run_instr("rep_stos0", 2'b10, 7'b1010101, 16'd0, 0, 1'b0, 1'b1, 1'b0);
      zfs[0] = 1'b1; zfs[1] = 1'b1; zfs[2] = 1'b0;
      run_instr("repz_cmps5", 2'b11, 7'b1010011, 16'd5, 0, 1'b0, 1'b1, 1'b0);
      run_instr("rep_lods_int", 2'b10, 7'b1010110, 16'd4, 2, 1'b0, 1'b0, 1'b0);
      run_instr("nopfx_movs", 2'b00, 7'b1010010, 16'd7, 0, 1'b0, 1'b1, 1'b0);
      reset_mid();
      zfs[0] = 1'b1;
      run_instr("repnz_scas_max", 2'b10, 7'b1010111, 16'hFFFF, 0, 1'b0, 1'b1, 1'b0);
      run_instr("rep_nonstr", 2'b11, 7'b0000001, 16'd5, 0, 1'b0, 1'b1, 1'b0);
      run_instr("int_at_zero", 2'b10, 7'b1010010, 16'd2, 2, 1'b0, 1'b1, 1'b0);
      run_instr("early_int", 2'b10, 7'b0110110, 16'd3, 1, 1'b1, 1'b1, 1'b0);

      for (int t = 0; t < 40; t++) begin
         logic [6:0]  op;
         logic [1:0]  pfx;
         logic [15:0] cx;
         int          ia;
         for (int i = 0; i < 64; i++) zfs[i] = ($urandom_range(0, 3) != 0);
         op  = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
         pfx = 2'($urandom);
         cx  = 16'($urandom_range(0, 20));
         ia  = $urandom_range(0, 4);
         run_instr("rand", pfx, op, cx, ia, (ia == 1) && $urandom_range(0, 1) == 1,
                   $urandom_range(0, 2) == 0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/zet_rep_seq.md
ZET_REP_SEQ -- requirements
Module: zet_rep_seq

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 start  in  1  one-cycle pulse; launches a string instruction; sampled only in IDLE.
REQ-004 prefix  in  2  [1]=rep present, [0]=1 repz / 0 repnz; sampled with start.
REQ-005 opcode  in  7  opcode[7:1]; sampled with start.
REQ-006 cx_in  in  16  CX value; sampled with start.
REQ-007 iter_req  out  1  request one string iteration from the execution unit.
REQ-008 iter_ack  in  1  execution unit accepted the request.
REQ-009 iter_done  in  1  one-cycle pulse; the accepted iteration finished.
REQ-010 zf  in  1  zero flag result; valid with iter_done.
REQ-011 ext_int  in  1  pending external interrupt, level.
REQ-012 cx_out  out  16  updated CX value.
REQ-013 cx_we  out  1  one-cycle CX write strobe.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 int_exit  out  1  qualifies done: instruction suspended for an interrupt; IP stays at the prefix.

Function
REQ-017 The block SHALL implement states IDLE, CHECK, ISSUE, WAIT and FIN.
REQ-018 The valid string ops SHALL be opcode[7:1] = 1010010 movs, 1010011 cmps, 1010101 stos, 1010110 lods, 1010111 scas, 0110110 ins and 0110111 outs.
REQ-019 rep_mode SHALL be latched as prefix[1] AND valid op; cmp_sca SHALL be latched as opcode[2] AND opcode[1].
REQ-020 IDLE + start SHALL latch cx_in into cnt, latch prefix[0], rep_mode and cmp_sca, clear first_done, and go to CHECK next cycle.
REQ-021 CHECK, rep_mode=1, cnt==0: the block SHALL go to FIN with int_exit=0 and issue no iteration.
REQ-022 CHECK, rep_mode=1, cnt!=0, ext_int=1, first_done=1: the block SHALL go to FIN with int_exit=1.
REQ-023 CHECK, all other cases: the block SHALL go to ISSUE.
REQ-024 ext_int SHALL be ignored before the first iteration, so at least one iteration always runs when cnt!=0.
REQ-025 ISSUE SHALL hold iter_req=1 until iter_ack=1, then go to WAIT; iter_req SHALL be 0 in WAIT.
REQ-026 WAIT + iter_done, rep_mode=1: cnt SHALL decrement by 1 (16-bit, no wrap beyond 0 because of REQ-021), cx_out=cnt-1, cx_we=1 for one cycle, and first_done SHALL be set.
REQ-027 exit_z SHALL be cmp_sca AND (latched prefix[0] ? ~zf : zf).
REQ-028 WAIT + iter_done with exit_z=1 or cnt-1==0 SHALL go to FIN with int_exit=0; otherwise the block SHALL return to CHECK.
REQ-029 When rep_mode=0 (no rep, or rep on a non-string op), the block SHALL run exactly one iteration, never assert cx_we, and go from WAIT + iter_done to FIN.
REQ-030 FIN SHALL assert done=1 for one cycle with int_exit held valid, then go to IDLE; int_exit SHALL be 0 whenever done=0.
REQ-031 When cnt reaches 0 in the same cycle ext_int is high, completion SHALL win (int_exit=0).
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 iter_done outside WAIT SHALL be ignored.
REQ-034 Iteration throughput SHALL be 3 cycles minimum per iteration (CHECK, ISSUE with same-cycle ack, WAIT with same-cycle done).

Reset
REQ-035 While rst=1, the block SHALL force state=IDLE, iter_req=0, cx_we=0, done=0, int_exit=0, busy=0, cx_out=0, cnt=0 and first_done=0.
REQ-036 rst asserted mid-instruction SHALL abort the instruction immediately: no further cx_we and no done pulse.

Verification
REQ-037 rep movs, cx_in=3, ack and done immediate -> 3 iter_req handshakes, cx_out 2,1,0 with cx_we, one done with int_exit=0.
REQ-038 rep stos, cx_in=0 -> no iter_req, no cx_we, done 2 cycles after start, int_exit=0.
REQ-039 repz cmps, cx_in=5, zf=1,1,0 -> 3 iterations, final cx_out=2, done with int_exit=0.
REQ-040 rep lods, cx_in=4, ext_int raised during iteration 2 -> after iteration 2, cx_out=2, done with int_exit=1, no third iter_req.
REQ-041 No prefix, opcode movs, cx_in=7 -> one iteration, cx_we never asserted, done.
REQ-042 rep movs, cx_in=10, rst pulsed in WAIT -> IDLE next cycle, iter_req=0, busy=0, no done.
